pipelined_control_unit: RTL and testbench

- Five-stage-pipeline successor to the single-cycle MIPS control decoder.
- Decodes op/funct in ID and carries the control bundle through ID/EX, EX/MEM and MEM/WB registers.
- Detects load-use hazards (stall plus bubble), flushes on taken branch and jump, and generates EX-stage forwarding selects.
- Sits beside the datapath pipeline registers; the datapath consumes the per-stage control outputs.

---
 rtl/pipelined_control_unit_if.sv | 52 +++++
 rtl/pipelined_control_unit.sv | 181 ++++++++++++++++++
 tb/tb_pipelined_control_unit.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/pipelined_control_unit_if.sv
// Control-unit bus between the ID-stage datapath and the pipelined control unit.
//   ID inputs  : op_in, func_in, id_rs/id_rt/id_rd, id_valid, branch_taken
//   ID outputs : stall, flush_if_id, id_jump, id_illegal
//   EX outputs : ex_ALUSrc, ex_regDst, ex_branch, ex_ALUOp, ex_func, fwd_a, fwd_b
//   MEM outputs: mem_memRead, mem_memWrite
//   WB outputs : wb_regWrite, wb_memToReg, wb_dest
// master = datapath side, slave = control unit.
interface pipelined_control_unit_if #(
  parameter int OP_W  = 6,
  parameter int REG_W = 5
);
  logic [OP_W-1:0]  op_in;
  logic [OP_W-1:0]  func_in;
  logic [REG_W-1:0] id_rs;
  logic [REG_W-1:0] id_rt;
  logic [REG_W-1:0] id_rd;
  logic             id_valid;
  logic             branch_taken;

  logic             stall;
  logic             flush_if_id;
  logic             id_jump;
  logic             id_illegal;
  logic             ex_ALUSrc;
  logic             ex_regDst;
  logic             ex_branch;
  logic [1:0]       ex_ALUOp;
  logic [OP_W-1:0]  ex_func;
  logic             mem_memRead;
  logic             mem_memWrite;
  logic             wb_regWrite;
  logic             wb_memToReg;
  logic [REG_W-1:0] wb_dest;
  logic [1:0]       fwd_a;
  logic [1:0]       fwd_b;

  modport master (
    output op_in, func_in, id_rs, id_rt, id_rd, id_valid, branch_taken,
    input  stall, flush_if_id, id_jump, id_illegal,
           ex_ALUSrc, ex_regDst, ex_branch, ex_ALUOp, ex_func,
           mem_memRead, mem_memWrite, wb_regWrite, wb_memToReg, wb_dest,
           fwd_a, fwd_b
  );

  modport slave (
    input  op_in, func_in, id_rs, id_rt, id_rd, id_valid, branch_taken,
    output stall, flush_if_id, id_jump, id_illegal,
           ex_ALUSrc, ex_regDst, ex_branch, ex_ALUOp, ex_func,
           mem_memRead, mem_memWrite, wb_regWrite, wb_memToReg, wb_dest,
           fwd_a, fwd_b
  );
endinterface

// File: rtl/pipelined_control_unit.sv
// Pipelined MIPS control unit: decodes op/funct in ID, carries the control
// bundle through ID/EX, EX/MEM and MEM/WB, detects load-use hazards,
// flushes on taken branch / jump and produces EX forwarding selects.
// Ports: clk, rst (sync, active high), bus (pipelined_control_unit_if.slave).
module pipelined_control_unit #(
  parameter int OP_W      = 6,
  parameter int REG_W     = 5,
  parameter int HAZARD_EN = 1
) (
  input logic                    clk,
  input logic                    rst,
  pipelined_control_unit_if.slave bus
);

  localparam logic [OP_W-1:0] OP_RTYPE = OP_W'(6'b000000);
  localparam logic [OP_W-1:0] OP_ADDI  = OP_W'(6'b001000);
  localparam logic [OP_W-1:0] OP_LW    = OP_W'(6'b100011);
  localparam logic [OP_W-1:0] OP_SW    = OP_W'(6'b101011);
  localparam logic [OP_W-1:0] OP_BEQ   = OP_W'(6'b000100);
  localparam logic [OP_W-1:0] OP_J     = OP_W'(6'b000010);

  // ID decode
  logic             d_regWrite, d_memToReg, d_memRead, d_memWrite;
  logic             d_branch, d_ALUSrc, d_regDst, d_jump, d_illegal, rt_used;
  logic [1:0]       d_ALUOp;
  logic [REG_W-1:0] id_dest;

  // pipeline state not visible on the bus
  logic             ex_regWrite, ex_memToReg, ex_memRead, ex_memWrite;
  logic [REG_W-1:0] ex_dest, ex_rs, ex_rt;
  logic             mem_regWrite, mem_memToReg;
  logic [REG_W-1:0] mem_dest;

  logic load_use, bubble;

  always_comb begin
    d_regWrite = 1'b0;
    d_memToReg = 1'b0;
    d_memRead  = 1'b0;
    d_memWrite = 1'b0;
    d_branch   = 1'b0;
    d_ALUSrc   = 1'b0;
    d_regDst   = 1'b0;
    d_jump     = 1'b0;
    d_illegal  = 1'b0;
    rt_used    = 1'b0;
    d_ALUOp    = 2'b00;
    if (bus.id_valid) begin
      case (bus.op_in)
        OP_RTYPE: begin
          // funct 0 is the canonical NOP and must leave no trace
          if (bus.func_in != '0) begin
            d_regWrite = 1'b1;
            d_regDst   = 1'b1;
            rt_used    = 1'b1;
          end
        end
        OP_ADDI: begin
          d_regWrite = 1'b1;
          d_ALUSrc   = 1'b1;
          d_ALUOp    = 2'b10;
        end
        OP_LW: begin
          d_regWrite = 1'b1;
          d_ALUSrc   = 1'b1;
          d_memRead  = 1'b1;
          d_memToReg = 1'b1;
          d_ALUOp    = 2'b10;
        end
        OP_SW: begin
          d_ALUSrc   = 1'b1;
          d_memWrite = 1'b1;
          d_ALUOp    = 2'b10;
          rt_used    = 1'b1;
        end
        OP_BEQ: begin
          d_branch   = 1'b1;
          d_ALUOp    = 2'b11;
          rt_used    = 1'b1;
        end
        OP_J: begin
          d_jump     = 1'b1;
          d_ALUOp    = 2'b10;
        end
        default: d_illegal = 1'b1;
      endcase
    end
  end

  assign id_dest = d_regDst ? bus.id_rd : bus.id_rt;

  assign load_use = bus.id_valid && ex_memRead && (ex_dest != '0) &&
                    ((ex_dest == bus.id_rs) || (rt_used && (ex_dest == bus.id_rt)));

  // a taken branch squashes whatever sits in ID, so it also cancels stall and jump
  assign bus.stall       = (HAZARD_EN != 0) && load_use && !bus.branch_taken;
  assign bus.id_jump     = d_jump && !bus.branch_taken && !bus.stall;
  assign bus.flush_if_id = bus.branch_taken || bus.id_jump;
  assign bus.id_illegal  = d_illegal;

  // J needs nothing downstream, so it travels as a bubble
  assign bubble = bus.stall || bus.branch_taken || d_jump;

  always_comb begin
    bus.fwd_a = 2'b00;
    if (mem_regWrite && (mem_dest != '0) && (mem_dest == ex_rs))
      bus.fwd_a = 2'b10;
    else if (bus.wb_regWrite && (bus.wb_dest != '0) && (bus.wb_dest == ex_rs))
      bus.fwd_a = 2'b01;
  end

  always_comb begin
    bus.fwd_b = 2'b00;
    if (mem_regWrite && (mem_dest != '0) && (mem_dest == ex_rt))
      bus.fwd_b = 2'b10;
    else if (bus.wb_regWrite && (bus.wb_dest != '0) && (bus.wb_dest == ex_rt))
      bus.fwd_b = 2'b01;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_regWrite      <= 1'b0;
      ex_memToReg      <= 1'b0;
      ex_memRead       <= 1'b0;
      ex_memWrite      <= 1'b0;
      bus.ex_branch    <= 1'b0;
      bus.ex_ALUSrc    <= 1'b0;
      bus.ex_regDst    <= 1'b0;
      bus.ex_ALUOp     <= 2'b00;
      bus.ex_func      <= '0;
      ex_dest          <= '0;
      ex_rs            <= '0;
      ex_rt            <= '0;
      mem_regWrite     <= 1'b0;
      mem_memToReg     <= 1'b0;
      bus.mem_memRead  <= 1'b0;
      bus.mem_memWrite <= 1'b0;
      mem_dest         <= '0;
      bus.wb_regWrite  <= 1'b0;
      bus.wb_memToReg  <= 1'b0;
      bus.wb_dest      <= '0;
    end else begin
      if (bubble) begin
        ex_regWrite   <= 1'b0;
        ex_memToReg   <= 1'b0;
        ex_memRead    <= 1'b0;
        ex_memWrite   <= 1'b0;
        bus.ex_branch <= 1'b0;
        bus.ex_ALUSrc <= 1'b0;
        bus.ex_regDst <= 1'b0;
        bus.ex_ALUOp  <= 2'b00;
        bus.ex_func   <= '0;
        ex_dest       <= '0;
        ex_rs         <= '0;
        ex_rt         <= '0;
      end else begin
        ex_regWrite   <= d_regWrite;
        ex_memToReg   <= d_memToReg;
        ex_memRead    <= d_memRead;
        ex_memWrite   <= d_memWrite;
        bus.ex_branch <= d_branch;
        bus.ex_ALUSrc <= d_ALUSrc;
        bus.ex_regDst <= d_regDst;
        bus.ex_ALUOp  <= d_ALUOp;
        bus.ex_func   <= bus.id_valid ? bus.func_in : '0;
        ex_dest       <= bus.id_valid ? id_dest : '0;
        ex_rs         <= bus.id_valid ? bus.id_rs : '0;
        ex_rt         <= bus.id_valid ? bus.id_rt : '0;
      end
      mem_regWrite     <= ex_regWrite;
      mem_memToReg     <= ex_memToReg;
      bus.mem_memRead  <= ex_memRead;
      bus.mem_memWrite <= ex_memWrite;
      mem_dest         <= ex_dest;
      bus.wb_regWrite  <= mem_regWrite;
      bus.wb_memToReg  <= mem_memToReg;
      bus.wb_dest      <= mem_dest;
    end
  end

endmodule

// File: tb/tb_pipelined_control_unit.sv
// Directed bench for pipelined_control_unit: reset, latency, load-use stall,
// forwarding priority, branch flush, jump, illegal opcode and r0 handling.
module tb_pipelined_control_unit;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  pipelined_control_unit_if #(.OP_W(6), .REG_W(5)) bus ();

  pipelined_control_unit #(.OP_W(6), .REG_W(5), .HAZARD_EN(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    if (obs != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // inputs change 1 time unit after a rising edge, then settle for checks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [5:0] op, input logic [5:0] fn,
                       input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input logic bt);
    bus.op_in        = op;
    bus.func_in      = fn;
    bus.id_rs        = rs;
    bus.id_rt        = rt;
    bus.id_rd        = rd;
    bus.id_valid     = 1'b1;
    bus.branch_taken = bt;
    #1;
  endtask

  task automatic idle();
    bus.op_in        = '0;
    bus.func_in      = '0;
    bus.id_rs        = '0;
    bus.id_rt        = '0;
    bus.id_rd        = '0;
    bus.id_valid     = 1'b0;
    bus.branch_taken = 1'b0;
    #1;
  endtask

  task automatic drain();
    idle();
    for (int i = 0; i < 4; i++) tick();
  endtask

  localparam logic [5:0] RT   = 6'b000000;
  localparam logic [5:0] ADDI = 6'b001000;
  localparam logic [5:0] LW   = 6'b100011;
  localparam logic [5:0] BEQ  = 6'b000100;
  localparam logic [5:0] JMP  = 6'b000010;
  localparam logic [5:0] ADD  = 6'b100000;
  localparam logic [5:0] SUB  = 6'b100010;

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;

    // reset must win over a live ADDI r1 in ID
    issue(ADDI, 6'd0, 5'd0, 5'd1, 5'd0, 1'b0);
    tick();
    tick();
    chk("rst_ex_alusrc", int'(bus.ex_ALUSrc), 0);
    chk("rst_ex_aluop", int'(bus.ex_ALUOp), 0);
    chk("rst_wb_regwrite", int'(bus.wb_regWrite), 0);
    chk("rst_wb_dest", int'(bus.wb_dest), 0);
    chk("rst_mem_memread", int'(bus.mem_memRead), 0);

    // ADDI r1 latency: EX after 1, WB after 3
    rst = 1'b0;
    #1;
    tick();
    chk("addi_ex_alusrc", int'(bus.ex_ALUSrc), 1);
    chk("addi_ex_aluop", int'(bus.ex_ALUOp), 2);
    idle();
    tick();
    chk("addi_wb_early", int'(bus.wb_regWrite), 0);
    tick();
    chk("addi_wb_regwrite", int'(bus.wb_regWrite), 1);
    chk("addi_wb_dest", int'(bus.wb_dest), 1);
    drain();

    // LW r2 ; ADD r3,r2,r4 -> one stall, one bubble, then WB forward
    issue(LW, 6'd0, 5'd0, 5'd2, 5'd0, 1'b0);
    tick();
    issue(RT, ADD, 5'd2, 5'd4, 5'd3, 1'b0);
    chk("lu_stall", int'(bus.stall), 1);
    tick();
    chk("lu_bubble_regdst", int'(bus.ex_regDst), 0);
    chk("lu_bubble_func", int'(bus.ex_func), 0);
    chk("lu_mem_memread", int'(bus.mem_memRead), 1);
    chk("lu_stall_released", int'(bus.stall), 0);
    tick();
    chk("lu_add_regdst", int'(bus.ex_regDst), 1);
    chk("lu_fwd_a", int'(bus.fwd_a), 1);
    chk("lu_fwd_b", int'(bus.fwd_b), 0);
    chk("lu_wb_memtoreg", int'(bus.wb_memToReg), 1);
    drain();

    // ADD r5,r1,r1 ; SUB r6,r5,r5 ; ADD r7,r5,r6
    issue(RT, ADD, 5'd1, 5'd1, 5'd5, 1'b0);
    tick();
    issue(RT, SUB, 5'd5, 5'd5, 5'd6, 1'b0);
    chk("fw_no_stall", int'(bus.stall), 0);
    tick();
    chk("fw_sub_fwd_a", int'(bus.fwd_a), 2);
    chk("fw_sub_fwd_b", int'(bus.fwd_b), 2);
    chk("fw_sub_func", int'(bus.ex_func), int'(SUB));
    issue(RT, ADD, 5'd5, 5'd6, 5'd7, 1'b0);
    tick();
    chk("fw_add7_fwd_a", int'(bus.fwd_a), 1);
    chk("fw_add7_fwd_b", int'(bus.fwd_b), 2);
    drain();

    // BEQ reaches EX, then taken branch flushes ID
    issue(BEQ, 6'd0, 5'd1, 5'd2, 5'd0, 1'b0);
    tick();
    chk("beq_ex_branch", int'(bus.ex_branch), 1);
    chk("beq_ex_aluop", int'(bus.ex_ALUOp), 3);
    issue(RT, ADD, 5'd8, 5'd8, 5'd9, 1'b1);
    chk("br_flush", int'(bus.flush_if_id), 1);
    tick();
    chk("br_ex_regdst", int'(bus.ex_regDst), 0);
    chk("br_ex_branch", int'(bus.ex_branch), 0);
    chk("br_ex_aluop", int'(bus.ex_ALUOp), 0);
    chk("br_ex_func", int'(bus.ex_func), 0);
    drain();

    // taken branch overrides a load-use stall and suppresses jump
    issue(LW, 6'd0, 5'd0, 5'd8, 5'd0, 1'b0);
    tick();
    issue(RT, ADD, 5'd8, 5'd0, 5'd9, 1'b1);
    chk("br_over_stall", int'(bus.stall), 0);
    chk("br_over_flush", int'(bus.flush_if_id), 1);
    issue(JMP, 6'd0, 5'd0, 5'd0, 5'd0, 1'b1);
    chk("br_over_jump", int'(bus.id_jump), 0);
    tick();
    chk("br_over_ex_alusrc", int'(bus.ex_ALUSrc), 0);
    drain();

    // J in ID, then illegal opcode that must never write back
    issue(JMP, 6'd0, 5'd3, 5'd4, 5'd5, 1'b0);
    chk("j_id_jump", int'(bus.id_jump), 1);
    chk("j_flush", int'(bus.flush_if_id), 1);
    chk("j_illegal", int'(bus.id_illegal), 0);
    tick();
    chk("j_ex_aluop", int'(bus.ex_ALUOp), 0);
    issue(6'b111111, 6'd0, 5'd0, 5'd7, 5'd7, 1'b0);
    chk("ill_id_illegal", int'(bus.id_illegal), 1);
    chk("ill_flush", int'(bus.flush_if_id), 0);
    tick();
    idle();
    chk("ill_clear", int'(bus.id_illegal), 0);
    tick();
    tick();
    chk("ill_wb_regwrite", int'(bus.wb_regWrite), 0);
    drain();

    // LW r0 ; ADD r10,r0,r0 -> r0 never stalls nor forwards
    issue(LW, 6'd0, 5'd0, 5'd0, 5'd0, 1'b0);
    tick();
    issue(RT, ADD, 5'd0, 5'd0, 5'd10, 1'b0);
    chk("r0_stall", int'(bus.stall), 0);
    tick();
    chk("r0_fwd_a", int'(bus.fwd_a), 0);
    chk("r0_fwd_b", int'(bus.fwd_b), 0);
    chk("r0_ex_regdst", int'(bus.ex_regDst), 1);

    // reset mid-flight discards everything in the pipe
    issue(ADDI, 6'd0, 5'd0, 5'd11, 5'd0, 1'b0);
    tick();
    rst = 1'b1;
    tick();
    chk("midrst_ex_alusrc", int'(bus.ex_ALUSrc), 0);
    chk("midrst_wb_regwrite", int'(bus.wb_regWrite), 0);
    rst = 1'b0;
    idle();
    tick();
    tick();
    chk("midrst_wb_after", int'(bus.wb_regWrite), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
